// File: rtl/cmd_sequencer.sv
// cmd_sequencer: issues NUM_CMDS command codes to the command engine over a
// start/ready_command handshake with a settle delay after each command, then
// runs the data phase (start_datos) and waits for the data engine to finish.
// A watchdog guards every handshake wait state, and abort returns to idle.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start_in
// S_ISSUE   | raise start, load settle delay and watchdog
// S_ACK_LO  | wait for ready_command low (engine accepted the command)
// S_ACK_HI  | wait for ready_command high (engine finished the command)
// S_DELAY   | settle delay; DELAY_CYCLES+1 cycles, then next command or exit
// S_WAITCOM | wait for the comms channel to go idle (bussy_com low)
// S_DATA    | hold start_datos for DATA_CYCLES cycles
// S_WAITD   | wait for the data engine to finish (bussy_e low), pulse done
module cmd_sequencer #(
  parameter int CMD_W          = 3,
  parameter int NUM_CMDS       = 4,
  parameter int DELAY_W        = 28,
  parameter int DELAY_CYCLES   = 50000000,
  parameter int DATA_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             abort,
  output logic [CMD_W-1:0] command,
  output logic             start,
  input  logic             ready_command,
  input  logic             bussy_com,
  output logic             start_datos,
  input  logic             bussy_e,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int DATA_W = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES + 1) : 1;
  localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CMD_W-1:0]   LAST_CMD  = CMD_W'(NUM_CMDS - 1);
  localparam logic [DELAY_W-1:0] DLY_LOAD  = DELAY_W'(DELAY_CYCLES);
  localparam logic [DATA_W-1:0]  DATA_LOAD = DATA_W'(DATA_CYCLES);
  localparam logic [WD_W-1:0]    WD_LOAD   = WD_W'(TIMEOUT_CYCLES);
  localparam bit                 WD_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_ACK_LO  = 3'd2,
    S_ACK_HI  = 3'd3,
    S_DELAY   = 3'd4,
    S_WAITCOM = 3'd5,
    S_DATA    = 3'd6,
    S_WAITD   = 3'd7
  } state_t;

  state_t              state_q;
  logic [CMD_W-1:0]    command_q;
  logic                start_q;
  logic                start_datos_q;
  logic                busy_q;
  logic                done_q;
  logic                timeout_err_q;
  logic [DELAY_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [DATA_W-1:0]   data_cnt_q, data_cnt_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                waiting;
  logic                wd_fire;

  assign command     = command_q;
  assign start       = start_q;
  assign start_datos = start_datos_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

  // Counter decrements and watchdog expiry: the watchdog only runs while a
  // handshake state is still waiting for its event; the event wins a tie.
  always_comb begin
    dly_cnt_d  = dly_cnt_q - DELAY_W'(1);
    data_cnt_d = data_cnt_q - DATA_W'(1);
    wd_cnt_d   = wd_cnt_q - WD_W'(1);
    waiting    = 1'b0;
    case (state_q)
      S_ACK_LO:  waiting = ready_command;
      S_ACK_HI:  waiting = !ready_command;
      S_WAITCOM: waiting = bussy_com;
      S_WAITD:   waiting = bussy_e;
      default:   waiting = 1'b0;
    endcase
    wd_fire = WD_EN && waiting && (wd_cnt_q == WD_W'(1));
  end

  // Sequencer FSM with registered outputs; abort outranks the watchdog,
  // which outranks normal transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      command_q     <= '0;
      start_q       <= 1'b0;
      start_datos_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      dly_cnt_q     <= '0;
      data_cnt_q    <= '0;
      wd_cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q       <= S_IDLE;
        command_q     <= '0;
        start_q       <= 1'b0;
        start_datos_q <= 1'b0;
        busy_q        <= 1'b0;
      end else if (wd_fire) begin
        state_q       <= S_IDLE;
        command_q     <= '0;
        start_q       <= 1'b0;
        start_datos_q <= 1'b0;
        busy_q        <= 1'b0;
        timeout_err_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_in) begin
              state_q       <= S_ISSUE;
              command_q     <= '0;
              timeout_err_q <= 1'b0;
              busy_q        <= 1'b1;
            end
          end
          S_ISSUE: begin
            start_q   <= 1'b1;
            dly_cnt_q <= DLY_LOAD;
            wd_cnt_q  <= WD_LOAD;
            state_q   <= S_ACK_LO;
          end
          S_ACK_LO: begin
            if (!ready_command) begin
              wd_cnt_q <= WD_LOAD;
              state_q  <= S_ACK_HI;
            end else begin
              wd_cnt_q <= wd_cnt_d;
            end
          end
          S_ACK_HI: begin
            if (ready_command) begin
              state_q <= S_DELAY;
            end else begin
              wd_cnt_q <= wd_cnt_d;
            end
          end
          S_DELAY: begin
            if (dly_cnt_q == '0) begin
              if (command_q == LAST_CMD) begin
                start_q  <= 1'b0;
                wd_cnt_q <= WD_LOAD;
                state_q  <= S_WAITCOM;
              end else begin
                command_q <= command_q + CMD_W'(1);
                state_q   <= S_ISSUE;
              end
            end else begin
              dly_cnt_q <= dly_cnt_d;
            end
          end
          S_WAITCOM: begin
            if (!bussy_com) begin
              start_datos_q <= 1'b1;
              data_cnt_q    <= DATA_LOAD;
              state_q       <= S_DATA;
            end else begin
              wd_cnt_q <= wd_cnt_d;
            end
          end
          S_DATA: begin
            if (data_cnt_q <= DATA_W'(1)) begin
              data_cnt_q <= '0;
              wd_cnt_q   <= WD_LOAD;
              state_q    <= S_WAITD;
            end else begin
              data_cnt_q <= data_cnt_d;
            end
          end
          S_WAITD: begin
            if (!bussy_e) begin
              start_datos_q <= 1'b0;
              done_q        <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= S_IDLE;
            end else begin
              wd_cnt_q <= wd_cnt_d;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
